// File: rtl/bit_word_aligner.sv
// Serial-to-parallel word aligner: hunts for the 10-bit boundary of a (3,2)/(2,3)-balanced code,
// confirms it over several words, then emits aligned words with a one-cycle valid strobe.
module bit_word_aligner #(
  parameter int lock_words_p  = 4,
  parameter int unlock_errs_p = 3
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       v_i,
  input  logic       bit_i,
  output logic [9:0] data_o,
  output logic       v_o,
  output logic       err_o,
  output logic       locked_o
);

  localparam int GoodW = $clog2(lock_words_p + 1);
  localparam int ErrW  = $clog2(unlock_errs_p + 1);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       fill_q, fill_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [ErrW-1:0]  err_cnt_q, err_cnt_d;
  logic [9:0]       data_q, data_d;
  logic             v_q, v_d;
  logic             err_q, err_d;

  logic [9:0] shift_n;
  logic [2:0] pop_hi, pop_lo;
  logic       legal, fill_done, boundary;

  function automatic logic [2:0] pop5(input logic [4:0] v);
    pop5 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
  endfunction

  // The window always includes the bit arriving this beat.
  assign shift_n   = {shift_q[8:0], bit_i};
  assign pop_hi    = pop5(shift_n[9:5]);
  assign pop_lo    = pop5(shift_n[4:0]);
  assign legal     = ((pop_hi == 3'd3) && (pop_lo == 3'd2)) ||
                     ((pop_hi == 3'd2) && (pop_lo == 3'd3));
  assign fill_done = (fill_q >= 4'd9);
  assign boundary  = (bit_cnt_q == 4'd9);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    fill_d    = fill_q;
    bit_cnt_d = bit_cnt_q;
    good_d    = good_q;
    err_cnt_d = err_cnt_q;
    data_d    = data_q;
    err_d     = err_q;
    v_d       = 1'b0;

    if (v_i) begin
      shift_d = shift_n;
      if (fill_q != 4'd10) fill_d = fill_q + 4'd1;

      unique case (state_q)
        HUNT: begin
          if (fill_done && legal) begin
            state_d   = CHECK;
            bit_cnt_d = 4'd0;
            good_d    = GoodW'(1);
          end
        end

        CHECK: begin
          if (boundary) begin
            bit_cnt_d = 4'd0;
            if (!legal) begin
              state_d = HUNT;
              good_d  = '0;
            end else if (good_q == GoodW'(lock_words_p - 1)) begin
              state_d   = LOCKED;
              good_d    = '0;
              err_cnt_d = '0;
            end else begin
              good_d = good_q + GoodW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        LOCKED: begin
          if (boundary) begin
            bit_cnt_d = 4'd0;
            data_d    = shift_n;
            v_d       = 1'b1;
            err_d     = !legal;
            if (legal) begin
              err_cnt_d = '0;
            end else if (err_cnt_q == ErrW'(unlock_errs_p - 1)) begin
              // The word that trips the unlock is still emitted, flagged as an error.
              state_d   = HUNT;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q + ErrW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= HUNT;
      shift_q   <= '0;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      good_q    <= '0;
      err_cnt_q <= '0;
      data_q    <= '0;
      v_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      good_q    <= good_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      v_q       <= v_d;
      err_q     <= err_d;
    end
  end

  assign data_o   = data_q;
  assign v_o      = v_q;
  assign err_o    = err_q;
  assign locked_o = (state_q == LOCKED);

endmodule

// File: tb/tb_bit_word_aligner.sv
// Scoreboard bench for bit_word_aligner: expected words are queued as their last bit is driven
// and matched (data, error flag, strobe cycle) whenever v_o is seen.
module tb_bit_word_aligner;

  logic       clk_i     = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       v_i       = 1'b0;
  logic       bit_i     = 1'b0;
  logic [9:0] data_o;
  logic       v_o;
  logic       err_o;
  logic       locked_o;

  localparam logic [9:0] WA = 10'b11100_00011;
  localparam logic [9:0] WB = 10'b00011_00111;
  localparam logic [9:0] WX = 10'h3FF;
  localparam logic [9:0] WC = 10'b11001_11000;

  typedef struct {
    logic [9:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  bit_word_aligner #(.lock_words_p(4), .unlock_errs_p(3)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .bit_i    (bit_i),
    .data_o   (data_o),
    .v_o      (v_o),
    .err_o    (err_o),
    .locked_o (locked_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: every strobe must match the oldest queued word.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (v_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_v_o", 32'(v_o), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("data_o", 32'(data_o), 32'(e.data));
        check("err_o", 32'(err_o), 32'(e.err));
        check("v_o_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_bit(input logic b, input logic push, input logic [9:0] w, input logic e);
    exp_t x;
    @(negedge clk_i);
    v_i   = 1'b1;
    bit_i = b;
    if (push) begin
      x.data = w;
      x.err  = e;
      x.cyc  = cyc + 1;
      sb_q.push_back(x);
    end
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      v_i   = 1'b0;
      bit_i = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_word(input logic [9:0] w, input logic emit, input logic e, input int gaps);
    int g[10];
    for (int i = 0; i < 10; i++) g[i] = 0;
    repeat (gaps) g[$urandom_range(1, 9)]++;
    for (int i = 0; i < 10; i++) begin
      idle(g[i]);
      send_bit(w[9-i], emit && (i == 9), w, e);
    end
  endtask

  task automatic word_chk(input logic [9:0] w, input logic emit, input logic e,
                          input logic exp_lock, input string tag);
    send_word(w, emit, e, 0);
    check(tag, 32'(locked_o), 32'(exp_lock));
  endtask

  // Alternating A,B stream: lock is expected after the 4th word, strobes from word first_emit.
  task automatic run_stream(input int n_words, input int first_emit, input int gaps);
    logic [9:0] w;
    for (int i = 0; i < n_words; i++) begin
      w = (i % 2 == 0) ? WA : WB;
      send_word(w, i >= first_emit, 1'b0, gaps);
      check($sformatf("locked_w%0d", i), 32'(locked_o), 32'(i >= 3));
    end
  endtask

  task automatic do_reset();
    idle(2);
    check("sb_drained", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    #1;
    check("rst_v_o", 32'(v_o), 0);
    check("rst_err_o", 32'(err_o), 0);
    check("rst_data_o", 32'(data_o), 0);
    check("rst_locked_o", 32'(locked_o), 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    // 1: clean aligned stream
    do_reset();
    run_stream(8, 4, 0);

    // 2: three-bit slip before the aligned stream
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 10'd0, 1'b0);
    run_stream(8, 4, 0);

    // 3: confirmation fails on the second word after the hit, then re-hunt and lock
    do_reset();
    word_chk(WA, 1'b0, 1'b0, 1'b0, "s3_hit");
    word_chk(WA, 1'b0, 1'b0, 1'b0, "s3_chk1");
    word_chk(WX, 1'b0, 1'b0, 1'b0, "s3_bad");
    word_chk(WA, 1'b0, 1'b0, 1'b0, "s3_rehit");
    word_chk(WB, 1'b0, 1'b0, 1'b0, "s3_g2");
    word_chk(WA, 1'b0, 1'b0, 1'b0, "s3_g3");
    word_chk(WB, 1'b0, 1'b0, 1'b1, "s3_lock");
    word_chk(WA, 1'b1, 1'b0, 1'b1, "s3_emit");

    // 4: error run while locked
    do_reset();
    run_stream(4, 99, 0);
    word_chk(WX, 1'b1, 1'b1, 1'b1, "s4_e1");
    word_chk(WX, 1'b1, 1'b1, 1'b1, "s4_e2");
    word_chk(WA, 1'b1, 1'b0, 1'b1, "s4_ok");
    word_chk(WX, 1'b1, 1'b1, 1'b1, "s4_e3");
    word_chk(WX, 1'b1, 1'b1, 1'b1, "s4_e4");
    word_chk(WX, 1'b1, 1'b1, 1'b0, "s4_unlock");

    // 5: aligned stream with idle gaps inside every word
    do_reset();
    run_stream(8, 4, 3);

    // 6: asynchronous reset mid-word while locked, then fill must restart
    do_reset();
    run_stream(5, 4, 0);
    idle(2);
    check("s6_data_pre", 32'(data_o), 32'(WA));
    for (int i = 0; i < 5; i++) send_bit(WB[9-i], 1'b0, 10'd0, 1'b0);
    #3;
    reset_n_i = 1'b0;
    #1;
    check("s6_v_o", 32'(v_o), 0);
    check("s6_locked_o", 32'(locked_o), 0);
    check("s6_data_o", 32'(data_o), 0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    check("s6_locked_rel", 32'(locked_o), 0);
    word_chk(WC, 1'b0, 1'b0, 1'b0, "s6_hit");
    word_chk(WA, 1'b0, 1'b0, 1'b0, "s6_g2");
    word_chk(WB, 1'b0, 1'b0, 1'b0, "s6_g3");
    word_chk(WA, 1'b0, 1'b0, 1'b1, "s6_lock");
    word_chk(WB, 1'b1, 1'b0, 1'b1, "s6_emit");

    idle(3);
    check("final_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
